// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: button commands, 1 Hz prescaler, saturating mm:ss count with lap freeze.
// Latency: a button command acts on the 3rd clock edge after the button rises; display lags count by 1 cycle.
// No backpressure: buttons are level inputs, outputs are free-running registers.
module stopwatch_controller #(
  parameter int TICKS_PER_SECOND = 50_000_000,
  parameter int PRESCALE_WIDTH   = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       lap_hold,
  output logic       overflow,
  output logic       sec_tick
);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

  localparam logic [PRESCALE_WIDTH-1:0] LAST_TICK = PRESCALE_WIDTH'(TICKS_PER_SECOND - 1);

  // Button vectors: bit 0 start/stop, bit 1 lap, bit 2 clear.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [2:0] pulse;

  logic clr_cmd;
  logic ss_cmd;
  logic lap_cmd;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [5:0]                min_cnt;
  logic [5:0]                sec_cnt;
  logic                      at_max;

  // Two-flop synchronizer followed by a delay flop for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      prev  <= 3'b000;
    end else begin
      sync1 <= {btn_clear, btn_lap, btn_start_stop};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

  // Coincident pulses resolve clear > start/stop > lap; losers are dropped.
  assign clr_cmd = pulse[2];
  assign ss_cmd  = pulse[0] & ~pulse[2];
  assign lap_cmd = pulse[1] & ~pulse[2] & ~pulse[0];

  assign at_max = (min_cnt == 6'd59) && (sec_cnt == 6'd59);

  // Control FSM together with the prescaler, live count and frozen/tracking display.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prescale <= '0;
      min_cnt  <= 6'd0;
      sec_cnt  <= 6'd0;
      minutes  <= 6'd0;
      seconds  <= 6'd0;
      running  <= 1'b0;
      lap_hold <= 1'b0;
      overflow <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      // Display follows the live count unless frozen; setting lap_hold captures this edge's value.
      if (!lap_hold) begin
        minutes <= min_cnt;
        seconds <= sec_cnt;
      end
      case (state)
        IDLE: begin
          if (clr_cmd) begin
            prescale <= '0;
            min_cnt  <= 6'd0;
            sec_cnt  <= 6'd0;
            minutes  <= 6'd0;
            seconds  <= 6'd0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
          end else if (ss_cmd) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        RUNNING: begin
          if (prescale == LAST_TICK) begin
            prescale <= '0;
            if (at_max) begin
              // Saturate at 59:59 and stop; resuming is locked out until a clear.
              overflow <= 1'b1;
              state    <= PAUSED;
              running  <= 1'b0;
            end else begin
              sec_tick <= 1'b1;
              if (sec_cnt == 6'd59) begin
                sec_cnt <= 6'd0;
                min_cnt <= min_cnt + 6'd1;
              end else begin
                sec_cnt <= sec_cnt + 6'd1;
              end
            end
          end else begin
            prescale <= prescale + 1'b1;
          end
          // Clear is deliberately ignored while running.
          if (ss_cmd) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (lap_cmd) begin
            lap_hold <= ~lap_hold;
          end
        end
        PAUSED: begin
          // Prescaler holds here so the fractional second survives a pause.
          if (clr_cmd) begin
            state    <= IDLE;
            prescale <= '0;
            min_cnt  <= 6'd0;
            sec_cnt  <= 6'd0;
            minutes  <= 6'd0;
            seconds  <= 6'd0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
          end else if (ss_cmd && !overflow) begin
            state   <= RUNNING;
            running <= 1'b1;
          end else if (lap_cmd) begin
            lap_hold <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with a 4-cycle second.
// Reference model tracks elapsed whole seconds and sub-second phase as plain integers.
// Directed scenarios plus a randomized button phase, checked every cycle.
module tb_stopwatch_controller;

  localparam int TPS = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       b_ss  = 1'b0;
  logic       b_lap = 1'b0;
  logic       b_clr = 1'b0;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       lap_hold;
  logic       overflow;
  logic       sec_tick;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;

  // Reference model: 0 idle, 1 running, 2 paused; counts held as total seconds.
  int m_mode;
  int m_total;
  int m_frac;
  int m_disp;
  bit m_lap;
  bit m_ovf;
  bit m_tick;
  bit h[3][3];   // [button][age]: levels sampled at the last three edges

  stopwatch_controller #(.TICKS_PER_SECOND(TPS), .PRESCALE_WIDTH(3)) dut (
    .clock(clock), .reset(reset),
    .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_clear(b_clr),
    .minutes(minutes), .seconds(seconds), .running(running),
    .lap_hold(lap_hold), .overflow(overflow), .sec_tick(sec_tick)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_total = 0; m_frac = 0; m_disp = 0;
    m_lap = 0; m_ovf = 0; m_tick = 0;
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 3; a++) h[b][a] = 0;
  endtask

  task automatic model_clear();
    m_frac = 0; m_total = 0; m_disp = 0; m_lap = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit p[3];
    bit lv[3];
    bit c_clr, c_ss, c_lap;
    int o_mode, o_total, o_frac;
    bit o_lap, o_ovf;
    lv[0] = b_ss; lv[1] = b_lap; lv[2] = b_clr;
    for (int b = 0; b < 3; b++) begin
      p[b] = h[b][1] && !h[b][2];
      h[b][2] = h[b][1]; h[b][1] = h[b][0]; h[b][0] = lv[b];
    end
    c_clr = p[2];
    c_ss  = p[0] && !p[2];
    c_lap = p[1] && !p[2] && !p[0];
    o_mode = m_mode; o_total = m_total; o_frac = m_frac; o_lap = m_lap; o_ovf = m_ovf;
    m_tick = 0;
    if (!o_lap) m_disp = o_total;
    if (o_mode == 0) begin
      if (c_clr) model_clear();
      else if (c_ss) m_mode = 1;
    end else if (o_mode == 1) begin
      if (o_frac == TPS - 1) begin
        m_frac = 0;
        if (o_total == 60 * 60 - 1) begin
          m_ovf = 1; m_mode = 2;
        end else begin
          m_total = o_total + 1; m_tick = 1;
        end
      end else begin
        m_frac = o_frac + 1;
      end
      if (c_ss) m_mode = 2;
      else if (c_lap) m_lap = !o_lap;
    end else begin
      if (c_clr) begin
        model_clear(); m_mode = 0;
      end else if (c_ss && !o_ovf) m_mode = 1;
      else if (c_lap) m_lap = 0;
    end
  endtask

  task automatic check_all();
    check("minutes",  minutes,  m_disp / 60);
    check("seconds",  seconds,  m_disp % 60);
    check("running",  running,  (m_mode == 1));
    check("lap_hold", lap_hold, m_lap);
    check("overflow", overflow, m_ovf);
    check("sec_tick", sec_tick, m_tick);
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge();
    #1;
    if (sec_tick === 1'b1) tick_count++;
    check_all();
  endtask

  task automatic press(input bit ss, input bit lap, input bit clr, input int hold, input int after);
    if (ss)  b_ss  = 1'b1;
    if (lap) b_lap = 1'b1;
    if (clr) b_clr = 1'b1;
    repeat (hold) cycle();
    b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
    repeat (after) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    repeat (3) cycle();
    check("rst_minutes", minutes, 0);
    check("rst_seconds", seconds, 0);
    check("rst_running", running, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    cycle();

    // Clear in idle changes nothing.
    press(0, 0, 1, 2, 6);
    check("idle_clear_running", running, 0);
    check("idle_clear_seconds", seconds, 0);

    // Start: command lands on the third edge.
    b_ss = 1'b1;
    cycle(); cycle();
    check("start_edge2_running", running, 0);
    cycle();
    check("start_edge3_running", running, 1);
    b_ss = 1'b0;
    tick_count = 0;
    repeat (245) cycle();
    check("tick_count_61", tick_count, 61);
    check("count_min_1", minutes, 1);
    check("count_sec_1", seconds, 1);

    // Pause, hold, resume: fraction is carried across the pause.
    press(1, 0, 0, 3, 20);
    check("paused_running", running, 0);
    press(1, 0, 0, 3, 10);

    // Lap freeze and release.
    press(0, 1, 0, 3, 12);
    check("lap_frozen", lap_hold, 1);
    press(0, 1, 0, 3, 6);
    check("lap_released", lap_hold, 0);

    // Lap set, then pause, then lap in pause releases the hold.
    press(0, 1, 0, 3, 5);
    press(1, 0, 0, 3, 5);
    press(0, 1, 0, 3, 5);
    check("paused_lap_release", lap_hold, 0);

    // Randomized button activity.
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) b_ss  = ~b_ss;
      if ($urandom_range(0, 11) == 0) b_lap = ~b_lap;
      if ($urandom_range(0, 23) == 0) b_clr = ~b_clr;
      cycle();
    end
    b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;

    // Overflow: run to saturation from a fresh start.
    do_reset();
    press(1, 0, 0, 3, 0);
    repeat (3600 * TPS + 10) cycle();
    check("ovf_flag", overflow, 1);
    check("ovf_running", running, 0);
    check("ovf_minutes", minutes, 59);
    check("ovf_seconds", seconds, 59);
    press(1, 0, 0, 3, 8);
    check("ovf_start_ignored", running, 0);
    press(0, 0, 1, 3, 3);
    check("ovf_clear_flag", overflow, 0);
    check("ovf_clear_minutes", minutes, 0);
    check("ovf_clear_seconds", seconds, 0);

    // Clear while running is ignored; clear beats start/stop when paused.
    press(1, 0, 0, 3, 10);
    press(0, 0, 1, 3, 3);
    check("run_clear_ignored", running, 1);
    press(1, 0, 0, 3, 5);
    press(1, 0, 1, 3, 3);
    check("prio_running", running, 0);
    check("prio_seconds", seconds, 0);
    repeat (10) cycle();
    check("prio_idle_seconds", seconds, 0);

    // Asynchronous reset mid-count.
    press(1, 0, 0, 3, 30);
    reset = 1'b0;
    #2;
    check("arst_minutes", minutes, 0);
    check("arst_seconds", seconds, 0);
    check("arst_running", running, 0);
    check("arst_sec_tick", sec_tick, 0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
    repeat (10) cycle();
    check("post_rst_running", running, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequences the stopwatch timebase and owns the minutes/seconds count.
- Its `minutes` and `seconds` outputs feed `seven_segment_driver` directly.
- Turns three debounced push-button levels into start/stop, lap-hold and clear commands using a 3-state FSM.
- Divides the system clock down to a 1 Hz count with a prescaler.

Parameters:
- TICKS_PER_SECOND, 50_000_000: clock cycles per counted second (50 MHz board clock). The bench overrides it to 4.
- PRESCALE_WIDTH, 26: width of the prescaler counter. Must satisfy 2^PRESCALE_WIDTH >= TICKS_PER_SECOND.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- btn_start_stop  input  1  debounced level, asynchronous to clock.
- btn_lap  input  1  debounced level, asynchronous to clock.
- btn_clear  input  1  debounced level, asynchronous to clock.
- minutes  output  6  displayed minutes, 0..59. Goes to seven_segment_driver.
- seconds  output  6  displayed seconds, 0..59. Goes to seven_segment_driver.
- running  output  1  high while the FSM is in RUNNING.
- lap_hold  output  1  high while the displayed value is frozen.
- overflow  output  1  sticky; set when the count saturates at 59:59.
- sec_tick  output  1  one-cycle pulse on each counted second.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register goes to 0, and the FSM goes to IDLE. When reset is released, the block starts from 00:00.
- Button inputs:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector that produces a one-cycle command pulse.
  - A command acts 3 clock edges after the button rises.
  - Holding a button produces exactly one pulse.
- Command priority when pulses coincide in the same cycle: clear > start_stop > lap. Lower-priority pulses in that cycle are dropped.
- FSM states: IDLE, RUNNING, PAUSED.
  - IDLE + start_stop -> RUNNING.
  - RUNNING + start_stop -> PAUSED.
  - PAUSED + start_stop -> RUNNING, unless overflow=1, in which case it is ignored and the FSM stays PAUSED.
  - IDLE or PAUSED + clear -> IDLE. Clears the prescaler, count, lap_hold and overflow.
  - RUNNING + clear -> ignored. The user must stop before clearing.
- Prescaler:
  - Increments only in RUNNING.
  - At TICKS_PER_SECOND-1 it wraps to 0 and the internal seconds count increments; sec_tick pulses in that same cycle.
  - Holds its value in PAUSED, so the fractional second is preserved across pause/resume.
- Count arithmetic:
  - Seconds 59 + tick -> 0, with minutes incremented.
  - At 59:59 + tick: the count holds at 59:59, overflow is set to 1, and the FSM goes to PAUSED (running=0) on the next edge.
  - Minutes never exceeds 59, and seconds never exceeds 59.
- Lap:
  - In RUNNING, a lap pulse toggles lap_hold.
  - Setting lap_hold captures the current internal count into the display registers and freezes them there.
  - While lap_hold=1, the internal count keeps advancing.
  - Clearing lap_hold makes the display track the live count again on the next edge.
  - In PAUSED, a lap pulse clears lap_hold if set; otherwise it is ignored.
  - In IDLE, a lap pulse is ignored.
- Outputs:
  - minutes and seconds are registered. With lap_hold=0 they equal the internal count one cycle later.
  - running, lap_hold and overflow are registered state.
  - sec_tick is registered and aligned with the count update.
- Reset mid-operation: takes effect immediately in any state, including while lap_hold=1 or overflow=1. No pending command survives reset.

Test Plan:
(All cases use TICKS_PER_SECOND=4.)
- Reset/idle: hold reset=0 for 3 cycles, then release -> minutes=0, seconds=0, running=0, lap_hold=0, overflow=0. Pulse btn_clear -> outputs unchanged.
- Start and count: pulse btn_start_stop -> running=1 after 3 edges. After 4*61 further cycles -> minutes=1, seconds=1, and 61 sec_tick pulses observed.
- Pause/resume fraction: run 6 cycles, pause for 20 cycles -> display constant. Resume -> the next sec_tick arrives 2 cycles after resume.
- Lap hold: running at 00:05, pulse btn_lap -> display frozen at 00:05. After 12 cycles the internal count is 00:08 and the display is still 00:05. Pulse btn_lap again -> display shows the live count, 00:08 or later.
- Overflow: preload by running 3599*4 cycles -> 59:59. After 4 more cycles -> still 59:59, overflow=1, running=0. btn_start_stop is ignored; btn_clear -> 00:00, overflow=0.
- Priority/clear rules: clear while RUNNING -> ignored. btn_clear and btn_start_stop rising in the same cycle while PAUSED -> IDLE at 00:00, not RUNNING. Reset asserted mid-count -> all outputs 0 asynchronously, before the next clock edge.
